// File: rtl/spatz_mem_responder_pkg.sv
// Shared types for the Spatz VLSU memory port and its scratch-memory responder.
// ELEN/NRVREG are fixed here; the responder derives all widths from them.
package spatz_mem_responder_pkg;

  localparam int unsigned ELEN           = 32;
  localparam int unsigned ELENB          = ELEN / 8;
  localparam int unsigned NRVREG         = 32;
  localparam int unsigned IdWidth        = $clog2(NRVREG);
  localparam int unsigned ReqIdWidth     = IdWidth + 1;
  localparam int unsigned MemErrCntWidth = 16;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;

  // Largest access size that fits one ELEN word.
  localparam mem_size_e MaxSize = mem_size_e'($clog2(ELENB));

  typedef struct packed {
    logic [ReqIdWidth-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    mem_size_e             size;
    logic                  we;
    logic [ELENB-1:0]      strb;
    logic [ELEN-1:0]       wdata;
    logic                  last;
    logic                  spec;
  } spatz_mem_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [ELEN-1:0]    rdata;
    logic               err;
  } spatz_mem_resp_t;

  // Natural alignment check on the low address bits for a given access size.
  function automatic logic addr_misaligned(input logic [2:0] addr_lsb, input mem_size_e size);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addr_lsb[0];
      MEM_W:   mis = |addr_lsb[1:0];
      default: mis = |addr_lsb[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/spatz_mem_sram.sv
// Behavioural single-port NumWords x ELEN array with byte-enabled write and a
// registered read port; the read register forms the first response stage.
module spatz_mem_sram
  import spatz_mem_responder_pkg::*;
#(
  parameter int unsigned NumWords = 1024,
  localparam int unsigned AddrW   = $clog2(NumWords)
) (
  input  logic              clk_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic [ELENB-1:0]  be_i,
  input  logic [ELEN-1:0]   wdata_i,
  output logic [ELEN-1:0]   rdata_o
);

  logic [ELEN-1:0] mem_q [NumWords];
  logic [ELEN-1:0] rdata_q;

  // Contents deliberately survive reset, so there is no reset branch here.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int i = 0; i < int'(ELENB); i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spatz_mem_responder.sv
// Fixed-latency, in-order memory responder with credit back-pressure: decode,
// SRAM access, optional delay stages and a fall-through response FIFO.
module spatz_mem_responder
  import spatz_mem_responder_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter logic [31:0] BaseAddr  = 32'h0,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RespDepth = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  spatz_mem_req_t            mem_req_i,
  input  logic                      mem_req_valid_i,
  output logic                      mem_req_ready_o,
  output spatz_mem_resp_t           mem_resp_o,
  output logic                      mem_resp_valid_o,
  input  logic                      mem_resp_ready_i,
  output logic [MemErrCntWidth-1:0] err_count_o
);

  localparam int unsigned AddrW    = $clog2(NumWords);
  localparam int unsigned ByteOffW = $clog2(ELENB);
  localparam int unsigned CntW     = $clog2(RespDepth + 1);
  localparam int unsigned PtrW     = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [32:0] MemBytes = 33'(NumWords) * 33'(ELENB);

  // valid/ready: a transfer happens on a rising edge where valid & ready are both
  // high; ready never looks at valid, and a response stays put until taken.
  logic req_hs, resp_hs;
  logic [CntW-1:0] outstanding_q, outstanding_d;

  assign mem_req_ready_o = (outstanding_q < CntW'(RespDepth));
  assign req_hs          = mem_req_valid_i & mem_req_ready_o;

  logic [31:0]      off;
  logic [AddrW-1:0] word_idx;
  logic             req_err;

  assign off      = mem_req_i.addr - BaseAddr;
  assign word_idx = off[ByteOffW +: AddrW];
  assign req_err  = (mem_req_i.addr < BaseAddr) | ({1'b0, off} >= MemBytes) |
                    (mem_req_i.size > MaxSize) |
                    addr_misaligned(mem_req_i.addr[2:0], mem_req_i.size);

  logic unused_req;
  assign unused_req = ^{mem_req_i.mode, mem_req_i.last, mem_req_i.id[ReqIdWidth-1]};

  logic [ELEN-1:0] sram_rdata;

  spatz_mem_sram #(
    .NumWords (NumWords)
  ) i_sram (
    .clk_i   (clk_i),
    .req_i   (req_hs & ~req_err),
    .we_i    (mem_req_i.we),
    .addr_i  (word_idx),
    .be_i    (mem_req_i.strb),
    .wdata_i (mem_req_i.wdata),
    .rdata_o (sram_rdata)
  );

  // Stage 1 metadata rides alongside the SRAM read register.
  logic               s0_valid_q;
  logic [IdWidth-1:0] s0_id_q;
  logic               s0_err_q;
  logic               s0_zero_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_valid_q <= 1'b0;
      s0_id_q    <= '0;
      s0_err_q   <= 1'b0;
      s0_zero_q  <= 1'b0;
    end else begin
      s0_valid_q <= req_hs;
      if (req_hs) begin
        s0_id_q   <= mem_req_i.id[IdWidth-1:0];
        s0_err_q  <= req_err & ~mem_req_i.spec;
        s0_zero_q <= mem_req_i.we | req_err;
      end
    end
  end

  spatz_mem_resp_t s0_resp;
  assign s0_resp = '{id: s0_id_q, rdata: (s0_zero_q ? '0 : sram_rdata), err: s0_err_q};

  logic            last_valid;
  spatz_mem_resp_t last_resp;

  generate
    if (Latency > 1) begin : g_pipe
      spatz_mem_resp_t   pipe_q [Latency-1];
      logic [Latency-2:0] pipe_vld_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_vld_q <= '0;
          for (int k = 0; k < int'(Latency) - 1; k++) pipe_q[k] <= '0;
        end else begin
          pipe_vld_q[0] <= s0_valid_q;
          pipe_q[0]     <= s0_resp;
          for (int k = 1; k < int'(Latency) - 1; k++) begin
            pipe_vld_q[k] <= pipe_vld_q[k-1];
            pipe_q[k]     <= pipe_q[k-1];
          end
        end
      end

      assign last_valid = pipe_vld_q[Latency-2];
      assign last_resp  = pipe_q[Latency-2];
    end else begin : g_nopipe
      assign last_valid = s0_valid_q;
      assign last_resp  = s0_resp;
    end
  endgenerate

  // Fall-through FIFO: an empty FIFO presents the last stage directly so a
  // ready consumer sees the response exactly Latency cycles after accept.
  spatz_mem_resp_t fifo_q [RespDepth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            fifo_empty, fifo_push, fifo_pop;
  spatz_mem_resp_t head_resp;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_empty       = (fifo_cnt_q == '0);
  assign head_resp        = fifo_empty ? last_resp : fifo_q[rd_ptr_q];
  assign mem_resp_valid_o = ~fifo_empty | last_valid;
  assign mem_resp_o       = mem_resp_valid_o ? head_resp : '0;
  assign resp_hs          = mem_resp_valid_o & mem_resp_ready_i;
  assign fifo_pop         = ~fifo_empty & mem_resp_ready_i;
  assign fifo_push        = last_valid & ~(fifo_empty & mem_resp_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (fifo_push && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + CntW'(1);
      else if (!fifo_push && fifo_pop) fifo_cnt_q <= fifo_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= last_resp;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (req_hs && !resp_hs)      outstanding_d = outstanding_q + CntW'(1);
    else if (!req_hs && resp_hs) outstanding_d = outstanding_q - CntW'(1);
  end

  logic [MemErrCntWidth-1:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      err_cnt_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (resp_hs && mem_resp_o.err && (err_cnt_q != {MemErrCntWidth{1'b1}}))
        err_cnt_q <= err_cnt_q + MemErrCntWidth'(1);
    end
  end

  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_spatz_mem_responder.sv
// Bench for spatz_mem_responder: directed vector table, back-pressure and reset
// sequences, then random traffic scored against a byte-addressed memory model.
module tb_spatz_mem_responder;
  import spatz_mem_responder_pkg::*;

  localparam int unsigned NumWords  = 1024;
  localparam logic [31:0] BaseAddr  = 32'h1000;
  localparam int unsigned Latency   = 1;
  localparam int unsigned RespDepth = 4;
  localparam int          SbW       = 39;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  spatz_mem_req_t  req;
  logic            req_valid;
  logic            req_ready;
  spatz_mem_resp_t resp;
  logic            resp_valid;
  logic            resp_ready;
  logic [15:0]     err_count;

  spatz_mem_responder #(
    .NumWords  (NumWords),
    .BaseAddr  (BaseAddr),
    .Latency   (Latency),
    .RespDepth (RespDepth)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .mem_req_i        (req),
    .mem_req_valid_i  (req_valid),
    .mem_req_ready_o  (req_ready),
    .mem_resp_o       (resp),
    .mem_resp_valid_o (resp_valid),
    .mem_resp_ready_i (resp_ready),
    .err_count_o      (err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]     model_byte [int unsigned];
  logic [SbW-1:0] exp_q [$];
  int             model_errs = 0;
  logic [SbW-1:0] sb_e;

  // Returns {data_known, id, rdata, err}; applies stores to the byte memory.
  function automatic logic [SbW-1:0] model_access(input spatz_mem_req_t r);
    logic        bad, chk;
    logic [31:0] data;
    int unsigned wa;
    bad = (r.addr < BaseAddr) ||
          (longint'(r.addr) >= longint'(BaseAddr) + longint'(NumWords * 4)) ||
          (int'(r.size) > 2) ||
          ((r.addr % (32'd1 << r.size)) != 0);
    data = '0;
    chk  = 1'b1;
    wa   = r.addr & ~32'd3;
    if (!bad && r.we) begin
      for (int i = 0; i < 4; i++)
        if (r.strb[i]) model_byte[wa + i] = r.wdata[8*i +: 8];
    end else if (!bad) begin
      for (int i = 0; i < 4; i++) begin
        if (model_byte.exists(wa + i)) data[8*i +: 8] = model_byte[wa + i];
        else chk = 1'b0;
      end
    end
    return {chk, r.id[4:0], data, bad & ~r.spec};
  endfunction

  // Scoreboard: responses are compared in order at handshake; accepts enqueue.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got response id=%0h expected none", resp.id);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_id", 64'(resp.id), 64'(sb_e[37:33]));
          check("sb_err", 64'(resp.err), 64'(sb_e[0]));
          if (sb_e[38]) check("sb_rdata", 64'(resp.rdata), 64'(sb_e[32:1]));
          if (sb_e[0]) model_errs++;
        end
      end
      if (req_valid && req_ready) exp_q.push_back(model_access(req));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic spatz_mem_req_t mk_req(input logic [31:0] addr, input logic we,
                                            input mem_size_e size, input logic [3:0] strb,
                                            input logic [31:0] wdata, input logic [5:0] id,
                                            input logic spec);
    spatz_mem_req_t r;
    r       = '0;
    r.addr  = addr;
    r.we    = we;
    r.size  = size;
    r.strb  = strb;
    r.wdata = wdata;
    r.id    = id;
    r.spec  = spec;
    return r;
  endfunction

  task automatic send(input spatz_mem_req_t r);
    int n;
    n = 0;
    @(posedge clk); #1;
    req       = r;
    req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_resp(output spatz_mem_resp_t r, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response expected one within 20 cycles");
    end
    r = resp;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    resp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    mem_size_e   size;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [5:0]  id;
    logic        spec;
    logic [4:0]  e_id;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t v(input logic [31:0] addr, input logic we, input mem_size_e size,
                             input logic [3:0] strb, input logic [31:0] wdata,
                             input logic [5:0] id, input logic spec, input logic [4:0] e_id,
                             input logic [31:0] e_rdata, input logic e_err);
    vec_t x;
    x = '{addr, we, size, strb, wdata, id, spec, e_id, e_rdata, e_err};
    return x;
  endfunction

  spatz_mem_resp_t r_got, snap;
  spatz_mem_req_t  bp [6];
  spatz_mem_req_t  rr;
  int              lat, idx, exp_errs;
  logic            stable, have_snap, seen, rand_on;
  int unsigned     w, lane;

  initial begin
    req        = '0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;

    vecs.push_back(v(32'h1004, 1, MEM_W, 4'hF, 32'hDEADBEEF, 6'h23, 0, 5'h03, 32'h0,        0));
    vecs.push_back(v(32'h1004, 0, MEM_W, 4'h0, 32'h0,        6'h01, 0, 5'h01, 32'hDEADBEEF, 0));
    vecs.push_back(v(32'h1004, 1, MEM_W, 4'h2, 32'h0000AA00, 6'h02, 0, 5'h02, 32'h0,        0));
    vecs.push_back(v(32'h1004, 0, MEM_W, 4'h0, 32'h0,        6'h03, 0, 5'h03, 32'hDEADAAEF, 0));
    vecs.push_back(v(32'h0FFC, 0, MEM_W, 4'h0, 32'h0,        6'h04, 0, 5'h04, 32'h0,        1));
    vecs.push_back(v(32'h0FFC, 0, MEM_W, 4'h0, 32'h0,        6'h05, 1, 5'h05, 32'h0,        0));
    vecs.push_back(v(32'h1002, 0, MEM_W, 4'h0, 32'h0,        6'h06, 0, 5'h06, 32'h0,        1));
    vecs.push_back(v(32'h1FFC, 1, MEM_W, 4'hF, 32'h12345678, 6'h27, 0, 5'h07, 32'h0,        0));
    vecs.push_back(v(32'h1FFC, 0, MEM_W, 4'h0, 32'h0,        6'h08, 0, 5'h08, 32'h12345678, 0));
    vecs.push_back(v(32'h2000, 0, MEM_W, 4'h0, 32'h0,        6'h09, 0, 5'h09, 32'h0,        1));
    vecs.push_back(v(32'h1008, 0, MEM_D, 4'h0, 32'h0,        6'h0A, 0, 5'h0A, 32'h0,        1));
    vecs.push_back(v(32'h1006, 1, MEM_W, 4'hF, 32'h0,        6'h0B, 0, 5'h0B, 32'h0,        1));
    vecs.push_back(v(32'h1005, 0, MEM_B, 4'h0, 32'h0,        6'h2C, 0, 5'h0C, 32'hDEADAAEF, 0));
    vecs.push_back(v(32'h1006, 0, MEM_H, 4'h0, 32'h0,        6'h0D, 0, 5'h0D, 32'hDEADAAEF, 0));
    vecs.push_back(v(32'h1007, 0, MEM_H, 4'h0, 32'h0,        6'h0E, 0, 5'h0E, 32'h0,        1));
    vecs.push_back(v(32'h1004, 0, MEM_W, 4'h0, 32'h0,        6'h0F, 0, 5'h0F, 32'hDEADAAEF, 0));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp", 64'(resp), 64'd0);
    check("reset_err_count", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, one request at a time with resp_ready high
    exp_errs = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      send(mk_req(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].strb,
                  vecs[i].wdata, vecs[i].id, vecs[i].spec));
      get_resp(r_got, lat);
      check($sformatf("vec%0d_id", i), 64'(r_got.id), 64'(vecs[i].e_id));
      check($sformatf("vec%0d_rdata", i), 64'(r_got.rdata), 64'(vecs[i].e_rdata));
      check($sformatf("vec%0d_err", i), 64'(r_got.err), 64'(vecs[i].e_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(Latency));
      if (vecs[i].e_err) exp_errs++;
    end
    wait_idle(50);
    @(posedge clk); #1;
    check("table_err_count", 64'(err_count), 64'(exp_errs));

    // Back-pressure: six back-to-back loads against a stalled consumer
    for (int i = 0; i < 6; i++)
      bp[i] = mk_req((i % 2 == 0) ? 32'h1004 : 32'h1FFC, 1'b0, MEM_W, 4'h0, 32'h0,
                     6'(6'h10 + i), 1'b0);
    resp_ready = 1'b0;
    idx        = 0;
    stable     = 1'b1;
    have_snap  = 1'b0;
    snap       = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_valid = (idx < 6);
      if (idx < 6) req = bp[idx];
      @(negedge clk);
      if (req_valid && req_ready) idx++;
      if (resp_valid) begin
        if (!have_snap) begin
          snap      = resp;
          have_snap = 1'b1;
        end else if (resp !== snap) begin
          stable = 1'b0;
        end
      end
    end
    check("bp_accepted", 64'(idx), 64'd4);
    check("bp_req_ready_low", 64'(req_ready), 64'd0);
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    check("bp_payload_stable", 64'(stable), 64'd1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_ready_bypass", 64'(req_ready), 64'd0);
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req       = bp[idx];
      @(negedge clk);
      if (req_ready) idx++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd6);
    wait_idle(50);

    // Reset with three requests in flight
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(mk_req(32'h1004, 1'b0, MEM_W, 4'h0, 32'h0, 6'(6'h20 + i), 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    model_errs = 0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    seen       = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("rst_no_stale_resp", 64'(seen), 64'd0);
    send(mk_req(32'h1004, 1'b0, MEM_W, 4'h0, 32'h0, 6'h31, 1'b0));
    get_resp(r_got, lat);
    check("rst_data_retained", 64'(r_got.rdata), 64'hDEADAAEF);
    check("rst_resp_id", 64'(r_got.id), 64'h11);
    wait_idle(50);

    // Random traffic with a 50% consumer
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          resp_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int n = 0; n < 300; n++) begin
          rr       = '0;
          rr.we    = 1'($urandom_range(0, 1));
          rr.size  = mem_size_e'($urandom_range(0, 3));
          w        = $urandom_range(0, 15);
          lane     = $urandom_range(0, 3);
          if ($urandom_range(0, 7) != 0) lane = lane & ~((32'd1 << rr.size) - 1);
          rr.addr  = BaseAddr + w * 4 + lane;
          if ($urandom_range(0, 15) == 0)
            rr.addr = ($urandom_range(0, 1) != 0) ? (32'h0FFC - w * 4) : (32'h2000 + w * 4);
          rr.strb  = 4'($urandom_range(0, 15));
          rr.wdata = $urandom;
          rr.id    = 6'($urandom_range(0, 63));
          rr.spec  = ($urandom_range(0, 3) == 0);
          rr.mode  = 2'($urandom_range(0, 3));
          rr.last  = 1'($urandom_range(0, 1));
          send(rr);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_on = 1'b0;
      end
    join
    wait_idle(200);
    @(posedge clk); #1;
    check("rand_err_count", 64'(err_count), 64'(model_errs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
